// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage of the pipelined RV32 core.
// Owns the PC and the single-outstanding instruction-memory handshake, and
// produces the IF/ID register (instruction, PC, PC+4, valid).
// A one-entry hold buffer absorbs a response that returns while decode is stalled.
// Optional build macro FETCH_STATS_EN adds saturating fetch/discard counters.
module instr_fetch_unit #(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_f,
  input  logic                   flush_d,
  input  logic                   pc_src_e,
  input  logic [ADDR_WIDTH-1:0]  pc_target_e,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0]  pc_d,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_d,
  output logic                   valid_d
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            discard_count
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  fetch_state_t           r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_req;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [INSTR_WIDTH-1:0] r_instr_d;
  logic [ADDR_WIDTH-1:0]  r_pc_d;
  logic [ADDR_WIDTH-1:0]  r_pc_plus4_d;
  logic                   r_valid_d;
  logic                   r_hold_valid;
  logic [INSTR_WIDTH-1:0] r_hold_instr;
  logic [ADDR_WIDTH-1:0]  r_hold_pc;

  logic [ADDR_WIDTH-1:0]  w_target;
  logic [ADDR_WIDTH-1:0]  w_pc_plus4;
  logic [ADDR_WIDTH-1:0]  w_hold_pc_plus4;

  // Redirect targets are word aligned by clearing the two low bits.
  assign w_target        = pc_target_e & ~ADDR_WIDTH'(3);
  assign w_pc_plus4      = r_pc + ADDR_WIDTH'(4);
  assign w_hold_pc_plus4 = r_hold_pc + ADDR_WIDTH'(4);

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;

  // Fetch FSM: PC, memory request, hold buffer and IF/ID register; redirect wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else if (pc_src_e) begin
      r_pc         <= w_target;
      r_hold_valid <= 1'b0;
      r_valid_d    <= 1'b0;
      r_instr_d    <= NOP_INSTR;
      if (r_req && !imem_valid) begin
        r_state <= DISCARD;
      end else begin
        r_state <= FETCH;
        r_req   <= 1'b1;
        r_addr  <= w_target;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_addr <= r_pc;
          end else if (imem_valid) begin
            if (stall_f) begin
              r_hold_valid <= 1'b1;
              r_hold_instr <= imem_rdata;
              r_hold_pc    <= r_pc;
              r_pc         <= w_pc_plus4;
              r_req        <= 1'b0;
              r_state      <= HOLD;
            end else begin
              r_instr_d    <= imem_rdata;
              r_pc_d       <= r_pc;
              r_pc_plus4_d <= w_pc_plus4;
              r_valid_d    <= 1'b1;
              r_pc         <= w_pc_plus4;
              r_addr       <= w_pc_plus4;
            end
          end
        end
        HOLD: begin
          if (!stall_f) begin
            r_instr_d    <= r_hold_instr;
            r_pc_d       <= r_hold_pc;
            r_pc_plus4_d <= w_hold_pc_plus4;
            r_valid_d    <= 1'b1;
            r_hold_valid <= 1'b0;
            r_state      <= FETCH;
            r_req        <= 1'b1;
            r_addr       <= r_pc;
          end
        end
        DISCARD: begin
          if (imem_valid) begin
            r_state <= FETCH;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
      if (flush_d) begin
        r_valid_d <= 1'b0;
        r_instr_d <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic        w_resp;
  logic        w_load_valid;
  logic        w_drop;
  logic [31:0] r_fetch_count;
  logic [31:0] r_discard_count;

  assign w_resp       = r_req & imem_valid;
  assign w_load_valid = !pc_src_e && !flush_d && !stall_f &&
                        (((r_state == FETCH) && w_resp) || (r_state == HOLD));
  assign w_drop       = pc_src_e ? (w_resp || r_hold_valid)
                                 : ((r_state == DISCARD) && imem_valid);

  assign fetch_count   = r_fetch_count;
  assign discard_count = r_discard_count;

  // Saturating counters of valid IF/ID loads and of responses thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count   <= '0;
      r_discard_count <= '0;
    end else begin
      if (w_load_valid && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_drop && (r_discard_count != 32'hFFFF_FFFF)) begin
        r_discard_count <= r_discard_count + 32'd1;
      end
    end
  end
`endif

endmodule
